// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing and the test-pattern colour table
// for the VGA raster timing generator.
package vga_pkg;

    typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} vga_phase_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_COORD_W  = 10;

    localparam int TP_BARS = 8;

    // RGB444 colour bars, left to right.
    function automatic logic [11:0] tp_bar_color(input int idx);
        logic [11:0] c;
        case (idx)
            0:       c = 12'hFFF;
            1:       c = 12'hFF0;
            2:       c = 12'h0FF;
            3:       c = 12'h0F0;
            4:       c = 12'hF0F;
            5:       c = 12'hF00;
            6:       c = 12'h00F;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase machine.
// Exposes the next phase so the parent can register its outputs in lockstep.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int W      = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    output logic [W-1:0] count,
    output vga_phase_t   phase,
    output vga_phase_t   phase_next,
    output logic         wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST_ACTIVE = W'(ACTIVE - 1);
    localparam logic [W-1:0] LAST_FP     = W'(ACTIVE + FP - 1);
    localparam logic [W-1:0] LAST_SYNC   = W'(ACTIVE + FP + SYNC - 1);
    localparam logic [W-1:0] LAST        = W'(TOTAL - 1);

    generate
        if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_len
            $error("vga_axis_counter: every phase length must be at least 1");
        end
        if (TOTAL > (1 << W)) begin : g_bad_width
            $error("vga_axis_counter: W too narrow for the axis total");
        end
    endgenerate

    logic [W-1:0] count_reg;
    vga_phase_t   phase_reg;

    assign wrap = step && (count_reg == LAST);

    always_comb begin
        phase_next = phase_reg;
        if (step) begin
            case (phase_reg)
                PH_ACTIVE: if (count_reg == LAST_ACTIVE) phase_next = PH_FRONT;
                PH_FRONT:  if (count_reg == LAST_FP)     phase_next = PH_SYNC;
                PH_SYNC:   if (count_reg == LAST_SYNC)   phase_next = PH_BACK;
                PH_BACK:   if (count_reg == LAST)        phase_next = PH_ACTIVE;
                default:   phase_next = PH_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
            phase_reg <= PH_ACTIVE;
        end else if (step) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + W'(1);
            phase_reg <= phase_next;
        end
    end

    assign count = count_reg;
    assign phase = phase_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered hsync/vsync/de/x/y and line/frame pulses.
// Define VGA_TEST_PATTERN_EN to add an rgb output carrying 8 vertical colour bars.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int COORD_W  = VGA_COORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [11:0]        rgb
`endif
);

    vga_phase_t h_phase, h_phase_next, v_phase, v_phase_next;
    logic       h_wrap, v_wrap, de_next;

    logic hsync_reg, vsync_reg, de_reg, line_start_reg, frame_start_reg;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(COORD_W)
    ) u_h_axis (
        .clk        (clk),
        .reset      (reset),
        .step       (pix_en),
        .count      (x),
        .phase      (h_phase),
        .phase_next (h_phase_next),
        .wrap       (h_wrap)
    );

    // The vertical axis only moves on the pixel tick that ends a line.
    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(COORD_W)
    ) u_v_axis (
        .clk        (clk),
        .reset      (reset),
        .step       (h_wrap),
        .count      (y),
        .phase      (v_phase),
        .phase_next (v_phase_next),
        .wrap       (v_wrap)
    );

    assign de_next = (h_phase_next == PH_ACTIVE) && (v_phase_next == PH_ACTIVE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_reg          <= 1'b0;
            hsync_reg       <= !SYNC_POL;
            vsync_reg       <= !SYNC_POL;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            line_start_reg  <= h_wrap;
            frame_start_reg <= h_wrap && v_wrap;
            if (pix_en) begin
                de_reg    <= de_next;
                hsync_reg <= (h_phase_next == PH_SYNC) ? SYNC_POL : !SYNC_POL;
                vsync_reg <= (v_phase_next == PH_SYNC) ? SYNC_POL : !SYNC_POL;
            end
        end
    end

    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign de          = de_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / TP_BARS;

    logic [COORD_W-1:0] x_next;
    logic [11:0]        rgb_reg;

    assign x_next = h_wrap ? '0 : x + COORD_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_reg <= 12'h000;
        end else if (pix_en) begin
            rgb_reg <= de_next ? tp_bar_color(int'(x_next) / BAR_W) : 12'h000;
        end
    end

    assign rgb = rgb_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: 640-wide default line timing with a short
// 9-line frame (4 active, 1 front, 2 sync, 2 back) to keep runs brief.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_en = 1'b0;
    logic       hsync, vsync, de, line_start, frame_start;
    logic [9:0] x, y;
`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] rgb;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start)
`ifdef VGA_TEST_PATTERN_EN
        ,
        .rgb         (rgb)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive pix_en just after an edge, then sample 1 ns after the next edge.
    task automatic step(input logic en);
        pix_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    // One full line from a fresh reset: x=1..799,0 and y ends at 1.
    task automatic run_line(input string tag);
        int de_n = 0, hs_n = 0, ls_n = 0, bad = 0;
        for (int i = 1; i <= 800; i++) begin
            step(1'b1);
            if (de === 1'b1) de_n++;
            if (hsync === 1'b0) hs_n++;
            if (line_start === 1'b1) ls_n++;
            if (x !== 10'(i % 800)) bad++;
            if (de !== ((x < 640) && (y < 4))) bad++;
            if (hsync !== !((x >= 656) && (x <= 751))) bad++;
            if (line_start !== (x == 0)) bad++;
            if (frame_start !== 1'b0) bad++;
`ifdef VGA_TEST_PATTERN_EN
            if (x == 0)   check({tag, "_rgb_x0"},   rgb, 12'hFFF);
            if (x == 80)  check({tag, "_rgb_x80"},  rgb, 12'hFF0);
            if (x == 639) check({tag, "_rgb_x639"}, rgb, 12'h000);
            if (x == 700) check({tag, "_rgb_x700"}, rgb, 12'h000);
`endif
        end
        check({tag, "_de_count"}, de_n, 640);
        check({tag, "_hs_low"}, hs_n, 96);
        check({tag, "_ls_count"}, ls_n, 1);
        check({tag, "_per_pixel_bad"}, bad, 0);
        check({tag, "_end_y"}, y, 1);
        $display("[TB] %s: line done de=%0d hs_low=%0d ls=%0d", tag, de_n, hs_n, ls_n);
    endtask

    initial begin
        int de_n, vs_n, fs_n, ls_n, bad, hold_bad;
        logic [9:0] px, py;
        logic pde, phs, pvs;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_de", de, 0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_line_start", line_start, 0);
        check("rst_frame_start", frame_start, 0);
        reset = 1'b0;
        step(1'b0);
        check("idle_after_release_x", x, 0);

        // Test 1: one line after reset
        run_line("t1");

        // Test 2: one full frame (9 lines) of free-running ticks
        de_n = 0; vs_n = 0; fs_n = 0; ls_n = 0; bad = 0;
        for (int i = 0; i < 7200; i++) begin
            step(1'b1);
            if (de === 1'b1) de_n++;
            if (vsync === 1'b0) vs_n++;
            if (frame_start === 1'b1) fs_n++;
            if (line_start === 1'b1) ls_n++;
            if (vsync !== !((y == 5) || (y == 6))) bad++;
            if (de !== ((x < 640) && (y < 4))) bad++;
            if (frame_start !== ((x == 0) && (y == 0))) bad++;
        end
        check("t2_frame_start_count", fs_n, 1);
        check("t2_line_start_count", ls_n, 9);
        check("t2_vsync_low_ticks", vs_n, 1600);
        check("t2_de_count", de_n, 2560);
        check("t2_per_pixel_bad", bad, 0);
        check("t2_end_x", x, 0);
        check("t2_end_y", y, 1);
        $display("[TB] t2: frame done fs=%0d ls=%0d vs_low=%0d de=%0d", fs_n, ls_n, vs_n, de_n);

        // Test 3: half-rate ticks from a fresh reset
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        step(1'b0);
        de_n = 0; vs_n = 0; ls_n = 0; bad = 0; hold_bad = 0;
        px = x; py = y; pde = de; phs = hsync; pvs = vsync;
        for (int i = 1; i <= 1600; i++) begin
            step(i[0]);
            if (i[0]) begin
                if (de === 1'b1) de_n++;
                if (hsync === 1'b0) vs_n++;
                if (line_start === 1'b1) ls_n++;
                if (x !== 10'(((i + 1) / 2) % 800)) bad++;
                if (hsync !== !((x >= 656) && (x <= 751))) bad++;
                px = x; py = y; pde = de; phs = hsync; pvs = vsync;
            end else begin
                if (x !== px || y !== py || de !== pde || hsync !== phs || vsync !== pvs) hold_bad++;
                if (line_start !== 1'b0 || frame_start !== 1'b0) hold_bad++;
            end
        end
        check("t3_de_count", de_n, 640);
        check("t3_hs_low", vs_n, 96);
        check("t3_ls_count", ls_n, 1);
        check("t3_per_pixel_bad", bad, 0);
        check("t3_hold_bad", hold_bad, 0);
        $display("[TB] t3: half-rate line done de=%0d hs_low=%0d ls=%0d", de_n, vs_n, ls_n);

        // Test 4: async reset while both axes sit in their sync pulses (x=700,y=5)
        run(800 * 4 + 700);
        check("t4_pre_x", x, 700);
        check("t4_pre_y", y, 5);
        check("t4_pre_hsync", hsync, 0);
        check("t4_pre_vsync", vsync, 0);
        #2 reset = 1'b1;
        #1;
        check("t4_async_x", x, 0);
        check("t4_async_y", y, 0);
        check("t4_async_de", de, 0);
        check("t4_async_hsync", hsync, 1);
        check("t4_async_vsync", vsync, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_line("t4");

        // Test 5: simultaneous line and frame wrap from x=799,y=8
        run(800 * 7 + 799);
        check("t5_pre_x", x, 799);
        check("t5_pre_y", y, 8);
        check("t5_pre_frame_start", frame_start, 0);
        step(1'b1);
        check("t5_wrap_x", x, 0);
        check("t5_wrap_y", y, 0);
        check("t5_line_start", line_start, 1);
        check("t5_frame_start", frame_start, 1);
        check("t5_wrap_de", de, 1);
        step(1'b0);
        check("t5_line_start_drop", line_start, 0);
        check("t5_frame_start_drop", frame_start, 0);
        check("t5_hold_x", x, 0);
        $display("[TB] t5: simultaneous wrap checked");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
